traffic_phase_timer: RTL and testbench

//   Multi-channel programmable phase timer for the traffic controller.

---
 rtl/traffic_phase_timer.sv | 77 +++++++
 tb/tb_traffic_phase_timer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/traffic_phase_timer.sv
// traffic_phase_timer: N_CH independent countdown channels sharing one prescaler tick.
module traffic_phase_timer #(
    parameter int N_CH     = 4,
    parameter int CNT_W    = 8,
    parameter int PRESCALE = 1
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [N_CH-1:0]       i_start,
    input  logic [N_CH-1:0]       i_abort,
    input  logic [N_CH-1:0]       i_periodic,
    input  logic [N_CH*CNT_W-1:0] i_duration,
    output logic [N_CH-1:0]       o_busy,
    output logic [N_CH-1:0]       o_done,
    output logic [N_CH*CNT_W-1:0] o_remaining,
    output logic                  o_tick
);
    localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    typedef enum logic {IDLE, RUN} state_e;
    logic [PRE_W-1:0] pre_q, pre_d;
    logic             tick_c, tick_q;
    assign tick_c = pre_q == PRE_W'(PRESCALE - 1);
    assign pre_d  = tick_c ? '0 : pre_q + PRE_W'(1);
    assign o_tick = tick_q;
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            pre_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= tick_c;
        end
    end
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        state_e           state_q, state_d;
        logic [CNT_W-1:0] dur, rem_q, rem_d;
        logic             done_q, done_d, reload;
        assign dur    = i_duration[k*CNT_W +: CNT_W];
        assign reload = i_periodic[k] && (dur != '0);
        // Priority: abort > start/retrigger > tick; a zero-duration start expires at once.
        always_comb begin
            state_d = state_q;
            rem_d   = rem_q;
            done_d  = 1'b0;
            if (i_abort[k]) begin
                state_d = IDLE;
                rem_d   = '0;
            end else if (i_start[k]) begin
                state_d = (dur != '0) ? RUN : IDLE;
                rem_d   = dur;
                done_d  = dur == '0;
            end else if (state_q == RUN && tick_c) begin
                if (rem_q > CNT_W'(1)) begin
                    rem_d = rem_q - CNT_W'(1);
                end else begin
                    done_d  = 1'b1;
                    state_d = reload ? RUN : IDLE;
                    rem_d   = reload ? dur : '0;
                end
            end
        end
        always_ff @(posedge i_clk) begin
            if (i_reset) begin
                state_q <= IDLE;
                rem_q   <= '0;
                done_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                rem_q   <= rem_d;
                done_q  <= done_d;
            end
        end
        assign o_busy[k]                      = state_q == RUN;
        assign o_done[k]                      = done_q;
        assign o_remaining[k*CNT_W +: CNT_W]  = rem_q;
    end
endmodule

// File: tb/tb_traffic_phase_timer.sv
// tb_traffic_phase_timer: randomized and directed checks of two DUTs (PRESCALE 1 and 4) against a tick-count model.
module tb_traffic_phase_timer;
    localparam int N = 4;
    localparam int W = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [N-1:0]   start = '0, abort = '0, periodic = '0;
    logic [N*W-1:0] dur = '0;
    logic [N-1:0]   busy1, done1, busy4, done4;
    logic [N*W-1:0] rem1, rem4;
    logic           tick1, tick4;
    int checks = 0;
    int errors = 0;
    bit chk_en = 0;
    int m_rem [2][N];
    bit m_done [2][N];
    bit m_tick [2];
    int m_n [2];
    always #5 clk = ~clk;
    traffic_phase_timer #(.N_CH(N), .CNT_W(W), .PRESCALE(1)) u_dut1 (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_abort(abort), .i_periodic(periodic),
        .i_duration(dur), .o_busy(busy1), .o_done(done1), .o_remaining(rem1), .o_tick(tick1));
    traffic_phase_timer #(.N_CH(N), .CNT_W(W), .PRESCALE(4)) u_dut4 (
        .i_clk(clk), .i_reset(rst), .i_start(start), .i_abort(abort), .i_periodic(periodic),
        .i_duration(dur), .o_busy(busy4), .o_done(done4), .o_remaining(rem4), .o_tick(tick4));
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    // Model: a channel is busy exactly while its remaining tick count is nonzero.
    task automatic model_step(input int d, input int p);
        bit t;
        int dk;
        if (rst) begin
            m_n[d]    = 0;
            m_tick[d] = 0;
            for (int k = 0; k < N; k++) begin
                m_rem[d][k]  = 0;
                m_done[d][k] = 0;
            end
        end else begin
            t         = (m_n[d] % p) == p - 1;
            m_tick[d] = t;
            m_n[d]++;
            for (int k = 0; k < N; k++) begin
                dk           = int'(dur[k*W +: W]);
                m_done[d][k] = 0;
                if (abort[k]) m_rem[d][k] = 0;
                else if (start[k]) begin
                    m_rem[d][k]  = dk;
                    m_done[d][k] = dk == 0;
                end else if (t && m_rem[d][k] != 0) begin
                    if (m_rem[d][k] == 1) begin
                        m_done[d][k] = 1;
                        m_rem[d][k]  = (periodic[k] && dk != 0) ? dk : 0;
                    end else m_rem[d][k]--;
                end
            end
        end
    endtask
    function automatic logic [N*W-1:0] exp_rem(input int d);
        for (int k = 0; k < N; k++) exp_rem[k*W +: W] = W'(m_rem[d][k]);
    endfunction
    function automatic logic [N-1:0] exp_busy(input int d);
        for (int k = 0; k < N; k++) exp_busy[k] = m_rem[d][k] != 0;
    endfunction
    function automatic logic [N-1:0] exp_done(input int d);
        for (int k = 0; k < N; k++) exp_done[k] = m_done[d][k];
    endfunction
    initial forever begin
        @(posedge clk);
        model_step(0, 1);
        model_step(1, 4);
        if (rst) chk_en = 1;
    end
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("p1_busy", busy1, exp_busy(0));
            check("p1_done", done1, exp_done(0));
            check("p1_rem", rem1, exp_rem(0));
            check("p1_tick", tick1, m_tick[0]);
            check("p4_busy", busy4, exp_busy(1));
            check("p4_done", done4, exp_done(1));
            check("p4_rem", rem4, exp_rem(1));
            check("p4_tick", tick4, m_tick[1]);
        end
    end
    int blen, dcnt, dat, first, zero_at, tcnt;
    bit found;
    int exp6 [4] = '{7, 6, 5, 8};
    initial begin
        repeat (2) @(negedge clk);
        check("reset_busy", busy1 | busy4, 0);
        check("reset_done", done1 | done4, 0);
        check("reset_rem", rem1 | rem4, 0);
        check("reset_tick", tick1 | tick4, 0);
        rst = 1'b0;
        @(negedge clk);
        dur[0 +: W] = 8'd25;
        start[0] = 1'b1;
        blen = 0; dcnt = 0; dat = 0; first = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            if (i == 1) begin
                start[0] = 1'b0;
                first = int'(rem1[0 +: W]);
            end
            if (busy1[0]) blen++;
            if (done1[0]) begin dcnt++; dat = i; end
        end
        check("t1_busy_len", blen, 25);
        check("t1_done_cnt", dcnt, 1);
        check("t1_done_at", dat, 26);
        check("t1_first_rem", first, 25);
        check("t1_end_rem", rem1[0 +: W], 0);
        dur[W +: W] = 8'd4;
        periodic[1] = 1'b1;
        start[1] = 1'b1;
        blen = 0; dcnt = 0; zero_at = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) start[1] = 1'b0;
            if (busy1[1]) blen++;
            else if (zero_at == 0) zero_at = i;
            if (done1[1]) dcnt++;
            if (i == 13) periodic[1] = 1'b0;
        end
        check("t2_busy_len", blen, 16);
        check("t2_busy_fall", zero_at, 17);
        check("t2_done_cnt", dcnt, 4);
        for (int r = 0; r < 2; r++) begin
            dur[2*W +: W] = 8'd10;
            start[2] = 1'b1;
            for (int i = 1; i <= 5; i++) begin
                @(negedge clk);
                if (i == 1) start[2] = 1'b0;
            end
            check("t3_rem6", rem1[2*W +: W], 6);
            start[2] = 1'b1;
            abort[2] = (r == 0);
            @(negedge clk);
            start[2] = 1'b0;
            abort[2] = 1'b0;
            check("t3_busy", busy1[2], r == 1);
            check("t3_rem", rem1[2*W +: W], (r == 0) ? 0 : 10);
            check("t3_no_done", done1[2], 0);
        end
        abort[2] = 1'b1;
        @(negedge clk);
        abort[2] = 1'b0;
        check("t3_abort", busy1[2], 0);
        dur[3*W +: W] = 8'd0;
        start[3] = 1'b1;
        @(negedge clk);
        start[3] = 1'b0;
        check("t4_done", done1[3], 1);
        check("t4_busy", busy1[3], 0);
        check("t4_rem", rem1[3*W +: W], 0);
        @(negedge clk);
        check("t4_done_once", done1[3], 0);
        dur = {8'd9, 8'd7, 8'd5, 8'd3};
        start = 4'hF;
        @(negedge clk);
        start = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("t5_busy", busy1 | busy4, 0);
        check("t5_rem", rem1 | rem4, 0);
        check("t5_done", done1 | done4, 0);
        dcnt = 0;
        repeat (12) begin
            @(negedge clk);
            if ((done1 | done4) != 0) dcnt++;
        end
        check("t5_no_done", dcnt, 0);
        dur[0 +: W] = 8'd2;
        for (int p = 0; p < 4; p++) begin
            found = 0;
            for (int i = 0; i < 8 && !found; i++) begin
                @(negedge clk);
                found = tick4;
            end
            check("t6_tick_seen", found, 1);
            repeat (p) @(negedge clk);
            start[0] = 1'b1;
            blen = 0;
            for (int i = 1; i <= 12; i++) begin
                @(negedge clk);
                if (i == 1) start[0] = 1'b0;
                if (busy4[0]) blen++;
            end
            check("t6_busy_len", blen, exp6[p]);
        end
        tcnt = 0;
        repeat (16) begin
            @(negedge clk);
            if (tick4) tcnt++;
        end
        check("t6_tick_cnt", tcnt, 4);
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            for (int k = 0; k < N; k++) begin
                start[k] = $urandom_range(0, 7) == 0;
                abort[k] = $urandom_range(0, 19) == 0;
                if ($urandom_range(0, 15) == 0) periodic[k] = $urandom_range(0, 1) == 1;
                if ($urandom_range(0, 3) == 0) dur[k*W +: W] = W'($urandom_range(0, 6));
            end
            rst = $urandom_range(0, 149) == 0;
        end
        @(negedge clk);
        start = '0; abort = '0; rst = 1'b0;
        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
